// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the reorder buffer and its neighbours.
package uarch_pkg;

  localparam int ARCH_XLEN = 32;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int REG_W     = 5;

  localparam logic [ARCH_XLEN-1:0] EXC_VEC = 32'h8000_0000;

  typedef struct packed {
    logic [ARCH_XLEN-1:0] pc;
    logic [REG_W-1:0]     rd;
    logic                 has_rd;
    logic                 is_valid;
    logic                 is_ready;
    logic                 is_branch;
    logic                 is_jump;
    logic                 is_store;
    logic                 has_exception;
    logic [ARCH_XLEN-1:0] result;
  } rob_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] dest_tag;
    logic [ARCH_XLEN-1:0] result;
    logic                 has_exception;
  } writeback_packet_t;

  typedef struct packed {
    logic                 we;
    logic [REG_W-1:0]     addr;
    logic [ARCH_XLEN-1:0] data;
  } prf_commit_write_port_t;

endpackage

// File: rtl/rob_nway_commit_select.sv
// In-order retirement scan over the oldest COMMIT_W slots; stops at the first
// not-ready slot and at the oldest slot that redirects the pipeline.
module rob_commit_select
  import uarch_pkg::*;
#(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
  input  rob_entry_t             [COMMIT_W-1:0] slot,
  output prf_commit_write_port_t [COMMIT_W-1:0] commit_port,
  output logic                   [COMMIT_W-1:0] store_lane,
  output logic                   [CNT_W-1:0]    commit_cnt,
  output logic                                  flush,
  output logic                   [ARCH_XLEN-1:0] redirect_pc
);

  always_comb begin
    logic alive;
    alive       = 1'b1;
    commit_port = '0;
    store_lane  = '0;
    commit_cnt  = '0;
    flush       = 1'b0;
    redirect_pc = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (alive && slot[k].is_valid && slot[k].is_ready) begin
        if (slot[k].has_exception) begin
          flush       = 1'b1;
          redirect_pc = EXC_VEC;
          alive       = 1'b0;
        end else if (slot[k].is_branch && slot[k].result[0]) begin
          // Mispredicted branch: result carries the corrected target, bit 0 is the flag.
          flush       = 1'b1;
          redirect_pc = {slot[k].result[ARCH_XLEN-1:1], 1'b0};
          alive       = 1'b0;
        end else begin
          commit_cnt          = commit_cnt + CNT_W'(1);
          commit_port[k].we   = slot[k].has_rd;
          commit_port[k].addr = slot[k].rd;
          commit_port[k].data = slot[k].is_jump ? slot[k].pc + ARCH_XLEN'(4) : slot[k].result;
          store_lane[k]       = slot[k].is_store;
          if (slot[k].is_jump) begin
            flush       = 1'b1;
            redirect_pc = {slot[k].result[ARCH_XLEN-1:1], 1'b0};
            alive       = 1'b0;
          end
        end
      end else begin
        alive = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer: in-order allocation, CDB snoop, in-order commit with
// same-cycle flush on exception, mispredict or jump.
module rob_nway
  import uarch_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int ALLOC_W  = 2,
  parameter int COMMIT_W = 2,
  parameter int WB_PORTS = 2,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int XLEN     = ARCH_XLEN
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                   [ALLOC_W-1:0]  alloc_req,
  output logic                   [ALLOC_W-1:0]  alloc_gnt,
  output logic [ALLOC_W-1:0]     [TAG_W-1:0]    alloc_tag,
  input  rob_entry_t             [ALLOC_W-1:0]  alloc_entry,
  input  writeback_packet_t      [WB_PORTS-1:0] wb,
  output prf_commit_write_port_t [COMMIT_W-1:0] commit_port,
  output logic                   [COMMIT_W-1:0] commit_store_val,
  output logic [COMMIT_W-1:0]    [TAG_W-1:0]    commit_store_id,
  output logic                                  flush,
  output logic                   [XLEN-1:0]     redirect_pc,
  output logic                   [TAG_W-1:0]    rob_head,
  output logic                   [TAG_W-1:0]    rob_tail,
  output logic                   [TAG_W:0]      rob_count
);

  localparam int CW     = TAG_W + 1;
  localparam int ACNT_W = $clog2(ALLOC_W + 1);
  localparam int CCNT_W = $clog2(COMMIT_W + 1);

  rob_entry_t                  entries_reg [DEPTH];
  logic       [TAG_W-1:0]      head_reg, tail_reg;
  logic       [CW-1:0]         count_reg, count_next;
  logic       [ACNT_W-1:0]     alloc_cnt;
  logic       [CCNT_W-1:0]     commit_cnt;
  rob_entry_t [COMMIT_W-1:0]   slot;
  logic [COMMIT_W-1:0][TAG_W-1:0] slot_tag;
  logic       [COMMIT_W-1:0]   store_lane;

  genvar gi, gj;
  generate
    for (gi = 0; gi < COMMIT_W; gi++) begin : g_slot
      assign slot_tag[gi]         = head_reg + TAG_W'(gi);
      assign slot[gi]             = entries_reg[slot_tag[gi]];
      assign commit_store_val[gi] = store_lane[gi];
      assign commit_store_id[gi]  = store_lane[gi] ? slot_tag[gi] : '0;
    end
    for (gi = 0; gi < ALLOC_W; gi++) begin : g_tag
      assign alloc_tag[gi] = tail_reg + TAG_W'(gi);
    end
    // Two CDB ports naming the same tag in one cycle is a producer bug.
    for (gi = 0; gi < WB_PORTS; gi++) begin : g_wb_a
      for (gj = gi + 1; gj < WB_PORTS; gj++) begin : g_wb_b
        assert property (@(posedge clk) disable iff (rst)
          !(wb[gi].valid && wb[gj].valid && wb[gi].dest_tag == wb[gj].dest_tag));
      end
    end
  endgenerate

  rob_commit_select #(.COMMIT_W(COMMIT_W), .CNT_W(CCNT_W)) u_commit_select (
    .slot        (slot),
    .commit_port (commit_port),
    .store_lane  (store_lane),
    .commit_cnt  (commit_cnt),
    .flush       (flush),
    .redirect_pc (redirect_pc)
  );

  // Grants use registered occupancy only, so commits free space a cycle later.
  always_comb begin
    logic          contig;
    logic [CW-1:0] free_slots;
    contig     = 1'b1;
    free_slots = CW'(DEPTH) - count_reg;
    alloc_gnt  = '0;
    alloc_cnt  = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      contig = contig & alloc_req[i];
      if (contig && !flush && (free_slots > CW'(i))) begin
        alloc_gnt[i] = 1'b1;
        alloc_cnt    = alloc_cnt + ACNT_W'(1);
      end
    end
  end

  assign count_next = count_reg + CW'(alloc_cnt) - CW'(commit_cnt);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int d = 0; d < DEPTH; d++) entries_reg[d].is_valid <= 1'b0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb[p].valid && entries_reg[wb[p].dest_tag].is_valid) begin
          entries_reg[wb[p].dest_tag].is_ready      <= 1'b1;
          entries_reg[wb[p].dest_tag].result        <= wb[p].result;
          entries_reg[wb[p].dest_tag].has_exception <= wb[p].has_exception;
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (CCNT_W'(k) < commit_cnt) entries_reg[slot_tag[k]].is_valid <= 1'b0;
      end
      for (int i = 0; i < ALLOC_W; i++) begin
        if (alloc_gnt[i]) begin
          entries_reg[alloc_tag[i]]               <= alloc_entry[i];
          entries_reg[alloc_tag[i]].is_valid      <= 1'b1;
          entries_reg[alloc_tag[i]].is_ready      <= 1'b0;
          entries_reg[alloc_tag[i]].has_exception <= 1'b0;
        end
      end
      head_reg  <= head_reg + TAG_W'(commit_cnt);
      tail_reg  <= tail_reg + TAG_W'(alloc_cnt);
      count_reg <= count_next;
    end
  end

  assign rob_head  = head_reg;
  assign rob_tail  = tail_reg;
  assign rob_count = count_reg;

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway with a commit scoreboard fed at writeback time.
module tb_rob_nway;
  import uarch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] alloc_req, alloc_gnt;
  logic [1:0][3:0] alloc_tag;
  rob_entry_t [1:0] alloc_entry;
  writeback_packet_t [1:0] wb;
  prf_commit_write_port_t [1:0] commit_port;
  logic [1:0] commit_store_val;
  logic [1:0][3:0] commit_store_id;
  logic flush;
  logic [31:0] redirect_pc;
  logic [3:0] rob_head, rob_tail;
  logic [4:0] rob_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        st;
  } exp_t;
  exp_t sb[$];

  rob_nway dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_tag(alloc_tag), .alloc_entry(alloc_entry), .wb(wb),
    .commit_port(commit_port), .commit_store_val(commit_store_val),
    .commit_store_id(commit_store_id), .flush(flush), .redirect_pc(redirect_pc),
    .rob_head(rob_head), .rob_tail(rob_tail), .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] rd_of(input int t);
    return 5'(t + 1);
  endfunction

  function automatic rob_entry_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic has_rd,
                                    input logic br, input logic jmp, input logic st);
    rob_entry_t e;
    e = '0;
    e.pc = pc; e.rd = rd; e.has_rd = has_rd;
    e.is_branch = br; e.is_jump = jmp; e.is_store = st;
    return e;
  endfunction

  task automatic idle();
    alloc_req   = '0;
    alloc_entry = '0;
    wb          = '0;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] res, input logic exc);
    wb[p].valid         = 1'b1;
    wb[p].dest_tag      = 4'(tag);
    wb[p].result        = res;
    wb[p].has_exception = exc;
  endtask

  task automatic push_exp(input int tag, input logic [4:0] rd, input logic [31:0] data,
                          input logic we, input logic st);
    exp_t e;
    e.tag = tag; e.rd = rd; e.data = data; e.we = we; e.st = st;
    sb.push_back(e);
  endtask

  task automatic check_commits(input int exp_n);
    int n;
    exp_t e;
    n = 0;
    for (int k = 0; k < 2; k++) begin
      if (commit_port[k].we || commit_store_val[k]) begin
        check("commit_lane", k, n);
        n++;
        if (sb.size() == 0) begin
          check("commit_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("commit_we", commit_port[k].we, e.we);
          check("commit_store", commit_store_val[k], e.st);
          if (e.we) begin
            check("commit_rd", commit_port[k].addr, e.rd);
            check("commit_data", commit_port[k].data, e.data);
          end
          if (e.st) check("commit_store_id", commit_store_id[k], e.tag);
        end
      end
    end
    check("commit_count", n, exp_n);
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
  task automatic tick(input int exp_n);
    #1;
    check_commits(exp_n);
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic check_ptrs(input string tag, input int head, input int tail, input int count);
    check({tag, "_head"}, rob_head, head);
    check({tag, "_tail"}, rob_tail, tail);
    check({tag, "_count"}, rob_count, count);
  endtask

  initial begin
    idle();
    do_reset();
    #1;
    check_ptrs("reset", 0, 0, 0);
    check("reset_flush", flush, 0);

    // 1: fill to full, two lanes per cycle, then expect no grants.
    for (int c = 0; c < 8; c++) begin
      alloc_req = 2'b11;
      alloc_entry[0] = mk(32'h1000 + 32'(8 * c), rd_of(2 * c), 1'b1, 1'b0, 1'b0, 1'b0);
      alloc_entry[1] = mk(32'h1004 + 32'(8 * c), rd_of(2 * c + 1), 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check("fill_gnt", alloc_gnt, 2'b11);
      check("fill_tag0", alloc_tag[0], 2 * c);
      check("fill_tag1", alloc_tag[1], 2 * c + 1);
      tick(0);
    end
    check("full_count", rob_count, 16);
    alloc_req = 2'b11;
    #1;
    check("full_gnt", alloc_gnt, 2'b00);
    tick(0);

    // 2: two results in one cycle, reversed port order, commit together.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      alloc_req = 2'b11;
      alloc_entry[0] = mk(32'h200, rd_of(2 * c), 1'b1, 1'b0, 1'b0, 1'b0);
      alloc_entry[1] = mk(32'h204, rd_of(2 * c + 1), 1'b1, 1'b0, 1'b0, 1'b0);
      tick(0);
    end
    set_wb(0, 1, 32'h11, 1'b0);
    set_wb(1, 0, 32'h10, 1'b0);
    push_exp(0, rd_of(0), 32'h10, 1'b1, 1'b0);
    push_exp(1, rd_of(1), 32'h11, 1'b1, 1'b0);
    tick(0);
    set_wb(0, 9, 32'h99, 1'b0);
    tick(2);
    #1;
    check_ptrs("t2", 2, 4, 2);
    tick(0);
    tick(0);

    // 3: partial readiness stops the scan.
    do_reset();
    alloc_req = 2'b11;
    alloc_entry[0] = mk(32'h300, rd_of(0), 1'b1, 1'b0, 1'b0, 1'b0);
    alloc_entry[1] = mk(32'h304, rd_of(1), 1'b1, 1'b0, 1'b0, 1'b0);
    tick(0);
    set_wb(0, 0, 32'hA0, 1'b0);
    push_exp(0, rd_of(0), 32'hA0, 1'b1, 1'b0);
    tick(0);
    tick(1);
    set_wb(1, 1, 32'hA1, 1'b0);
    push_exp(1, rd_of(1), 32'hA1, 1'b1, 1'b0);
    tick(0);
    tick(1);
    #1;
    check_ptrs("t3", 2, 2, 0);

    // 4: mispredicted branch at the head flushes and blocks allocation.
    do_reset();
    alloc_req = 2'b11;
    alloc_entry[0] = mk(32'h400, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    alloc_entry[1] = mk(32'h404, rd_of(1), 1'b1, 1'b0, 1'b0, 1'b0);
    tick(0);
    set_wb(0, 0, 32'h101, 1'b0);
    set_wb(1, 1, 32'h5, 1'b0);
    tick(0);
    alloc_req = 2'b11;
    #1;
    check("br_flush", flush, 1);
    check("br_redirect", redirect_pc, 32'h100);
    check("br_gnt", alloc_gnt, 2'b00);
    tick(0);
    #1;
    check_ptrs("br_after", 0, 0, 0);
    check("br_flush_after", flush, 0);

    // 5: jump commits its link value and redirects; then an exception.
    do_reset();
    alloc_req = 2'b01;
    alloc_entry[0] = mk(32'h40, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(0);
    set_wb(0, 0, 32'h80, 1'b0);
    push_exp(0, 5'd5, 32'h44, 1'b1, 1'b0);
    tick(0);
    #1;
    check("jmp_flush", flush, 1);
    check("jmp_redirect", redirect_pc, 32'h80);
    tick(1);
    #1;
    check_ptrs("jmp_after", 0, 0, 0);
    alloc_req = 2'b01;
    alloc_entry[0] = mk(32'h500, rd_of(0), 1'b1, 1'b0, 1'b0, 1'b0);
    tick(0);
    set_wb(1, 0, 32'h1, 1'b1);
    tick(0);
    #1;
    check("exc_flush", flush, 1);
    check("exc_redirect", redirect_pc, EXC_VEC);
    tick(0);
    #1;
    check_ptrs("exc_after", 0, 0, 0);

    // 6: wrap-around commit, store release, then reset mid-stream.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      alloc_req = 2'b11;
      alloc_entry[0] = mk(32'h600, rd_of(2 * c), 1'b1, 1'b0, 1'b0, 1'b0);
      alloc_entry[1] = mk(32'h604, rd_of(2 * c + 1), 1'b1, 1'b0, 1'b0, 1'b0);
      tick(0);
    end
    for (int c = 0; c < 7; c++) begin
      set_wb(0, 2 * c, 32'h600 + 32'(2 * c), 1'b0);
      set_wb(1, 2 * c + 1, 32'h600 + 32'(2 * c + 1), 1'b0);
      push_exp(2 * c, rd_of(2 * c), 32'h600 + 32'(2 * c), 1'b1, 1'b0);
      push_exp(2 * c + 1, rd_of(2 * c + 1), 32'h600 + 32'(2 * c + 1), 1'b1, 1'b0);
      tick(c == 0 ? 0 : 2);
    end
    tick(2);
    #1;
    check_ptrs("wrap_pre", 14, 14, 0);
    alloc_req = 2'b11;
    alloc_entry[0] = mk(32'h700, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    alloc_entry[1] = mk(32'h704, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("wrap_tag0", alloc_tag[0], 14);
    check("wrap_tag1", alloc_tag[1], 15);
    tick(0);
    alloc_req = 2'b11;
    alloc_entry[0] = mk(32'h708, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    alloc_entry[1] = mk(32'h70C, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("wrap_tag2", alloc_tag[0], 0);
    check("wrap_tag3", alloc_tag[1], 1);
    tick(0);
    set_wb(0, 14, 32'hE0, 1'b0);
    set_wb(1, 15, 32'hF0, 1'b0);
    push_exp(14, 5'd7, 32'hE0, 1'b1, 1'b0);
    push_exp(15, 5'd0, 32'hF0, 1'b0, 1'b1);
    tick(0);
    tick(2);
    #1;
    check_ptrs("wrap_post", 0, 2, 2);
    set_wb(0, 0, 32'h1, 1'b0);
    set_wb(1, 1, 32'h2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    check_ptrs("midrst", 0, 0, 0);
    check("midrst_flush", flush, 0);
    tick(0);
    tick(0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
